mem_bus_arbiter: RTL

//  Shares the single main-memory bus between the fetch-stage I-cache refill port and the

---
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port main-memory arbiter: D-cache has priority, I-cache is guaranteed a grant
// after MAX_DC_STREAK consecutive D grants. One memory transaction in flight.
module mem_bus_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int LINE_W        = 128,
  parameter int MAX_DC_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_in,
  input  logic [ADDR_W-1:0] ic_addr_in,
  output logic              ic_resp_out,
  output logic [LINE_W-1:0] ic_line_out,
  input  logic              dc_req_in,
  input  logic              dc_we_in,
  input  logic [ADDR_W-1:0] dc_addr_in,
  input  logic [LINE_W-1:0] dc_wdata_in,
  output logic              dc_resp_out,
  output logic [LINE_W-1:0] dc_line_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [LINE_W-1:0] mem_wdata_out,
  input  logic              mem_valid_in,
  input  logic [LINE_W-1:0] mem_rdata_in,
  output logic              busy_out
);

  localparam int CNT_W = $clog2(MAX_DC_STREAK + 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DC_STREAK);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, RESPOND} state_e;

  state_e             state_q, state_d;
  logic               owner_dc_q, owner_dc_d;
  logic [CNT_W-1:0]   streak_q, streak_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               ic_resp_q, ic_resp_d;
  logic               dc_resp_q, dc_resp_d;
  logic [LINE_W-1:0]  ic_line_q, ic_line_d;
  logic [LINE_W-1:0]  dc_line_q, dc_line_d;
  logic               busy_q, busy_d;
  logic               pick_dc;
  logic [LINE_W-1:0]  cap_data;

  always_comb begin
    state_d     = state_q;
    owner_dc_d  = owner_dc_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_resp_d   = 1'b0;
    dc_resp_d   = 1'b0;
    ic_line_d   = ic_line_q;
    dc_line_d   = dc_line_q;
    // D wins ties unless I has already waited through a full streak of D grants
    pick_dc     = dc_req_in && !(ic_req_in && streak_q == STREAK_MAX);
    cap_data    = mem_we_q ? '0 : mem_rdata_in;

    case (state_q)
      IDLE: begin
        if (ic_req_in && pick_dc)
          streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
        else
          streak_d = '0;
        if (ic_req_in || dc_req_in) begin
          state_d     = WAIT_MEM;
          owner_dc_d  = pick_dc;
          mem_req_d   = 1'b1;
          mem_we_d    = pick_dc & dc_we_in;
          mem_addr_d  = pick_dc ? dc_addr_in : ic_addr_in;
          mem_wdata_d = pick_dc ? dc_wdata_in : '0;
        end
      end
      WAIT_MEM: begin
        if (mem_valid_in) begin
          state_d   = RESPOND;
          mem_req_d = 1'b0;
          if (owner_dc_q) begin
            dc_resp_d = 1'b1;
            dc_line_d = cap_data;
          end else begin
            ic_resp_d = 1'b1;
            ic_line_d = cap_data;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_dc_q  <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_resp_q   <= 1'b0;
      dc_resp_q   <= 1'b0;
      ic_line_q   <= '0;
      dc_line_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dc_q  <= owner_dc_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_resp_q   <= ic_resp_d;
      dc_resp_q   <= dc_resp_d;
      ic_line_q   <= ic_line_d;
      dc_line_q   <= dc_line_d;
      busy_q      <= busy_d;
    end
  end

  assign ic_resp_out   = ic_resp_q;
  assign ic_line_out   = ic_line_q;
  assign dc_resp_out   = dc_resp_q;
  assign dc_line_out   = dc_line_q;
  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign busy_out      = busy_q;

endmodule
